shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_shift_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - command sequencer driving a register file and barrel shifter
//
// Purpose:
//   Accepts one LOAD / SHL / SHR command at a time. It steers an external
//   register file, left/right barrel shifters and a write-back mux so that
//   the command is carried out over one or two write passes.
//   Shift amounts above 7 are split into two passes: 7, then the remainder.
//   Every output is decoded from the registered state and the latched
//   command fields only.
//
// Ports:
//   clk         in   1  rising-edge clock
//   reset       in   1  synchronous, active-low reset
//   cmd_valid   in   1  command present
//   cmd_ready   out  1  high only in IDLE
//   cmd_op      in   2  00 LOAD, 01 SHL, 10 SHR, 11 illegal
//   cmd_src     in   3  shift source register
//   cmd_dst     in   3  destination register
//   cmd_amt     in   4  logical shift amount 0..15
//   cmd_data    in   8  LOAD immediate
//   rf_rd_addr  out  3  register-file read address
//   rf_wr_addr  out  3  register-file write address
//   rf_wr       out  1  register-file write enable
//   sh_ctrl     out  3  barrel-shifter amount
//   sh_sel      out  1  0 left result, 1 right result
//   wb_sel      out  1  0 rf_d_in, 1 shifter output
//   rf_d_in     out  8  immediate toward the write-back mux
//   busy        out  1  not IDLE
//   done        out  1  one-cycle completion pulse
//   err         out  1  with done: illegal op
//   ops_cnt     out  8  completed commands, wraps at 256

module shift_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_src,
  input  logic [2:0] cmd_dst,
  input  logic [3:0] cmd_amt,
  input  logic [7:0] cmd_data,
  output logic [2:0] rf_rd_addr,
  output logic [2:0] rf_wr_addr,
  output logic       rf_wr,
  output logic [2:0] sh_ctrl,
  output logic       sh_sel,
  output logic       wb_sel,
  output logic [7:0] rf_d_in,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] ops_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SH1  = 3'd2,
    ST_SH2  = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  state_t     state_q;
  state_t     state_d;

  logic [1:0] op_q;
  logic [2:0] src_q;
  logic [2:0] dst_q;
  logic [3:0] amt_q;
  logic [7:0] data_q;

  logic       accept;
  logic       amt_split;
  logic [2:0] pass1_amt;
  logic [3:0] pass2_rem;
  logic [2:0] pass2_amt;

  assign accept    = (state_q == ST_IDLE) && cmd_valid;

  // Amounts 8..15 need a second pass.
  assign amt_split = amt_q[3];
  assign pass1_amt = amt_split ? 3'd7 : amt_q[2:0];

  // The second pass shifts by amt-7. For amt=15 that is 8, which does not
  // fit the 3-bit shifter control. A total shift of 14 already clears an
  // 8-bit value, so saturating at 7 gives the same register result.
  assign pass2_rem = amt_q - 4'd7;
  assign pass2_amt = pass2_rem[3] ? 3'd7 : pass2_rem[2:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= 2'd0;
      src_q   <= 3'd0;
      dst_q   <= 3'd0;
      amt_q   <= 4'd0;
      data_q  <= 8'd0;
      ops_cnt <= 8'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= cmd_op;
        src_q  <= cmd_src;
        dst_q  <= cmd_dst;
        amt_q  <= cmd_amt;
        data_q <= cmd_data;
      end
      // Illegal ops also pass through FIN, so they are counted too.
      if (state_q == ST_FIN) begin
        ops_cnt <= ops_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD: state_d = ST_LOAD;
            OP_SHL:  state_d = ST_SH1;
            OP_SHR:  state_d = ST_SH1;
            OP_ILL:  state_d = ST_FIN;
            default: state_d = ST_FIN;
          endcase
        end
      end
      ST_LOAD: state_d = ST_FIN;
      ST_SH1:  state_d = amt_split ? ST_SH2 : ST_FIN;
      ST_SH2:  state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    rf_rd_addr = 3'd0;
    rf_wr_addr = 3'd0;
    rf_wr      = 1'b0;
    sh_ctrl    = 3'd0;
    sh_sel     = 1'b0;
    wb_sel     = 1'b0;
    rf_d_in    = 8'd0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_LOAD: begin
        rf_wr      = 1'b1;
        rf_wr_addr = dst_q;
        rf_d_in    = data_q;
      end
      ST_SH1: begin
        rf_rd_addr = src_q;
        sh_ctrl    = pass1_amt;
        sh_sel     = (op_q == OP_SHR);
        wb_sel     = 1'b1;
        rf_wr      = 1'b1;
        rf_wr_addr = dst_q;
      end
      ST_SH2: begin
        // Second pass works on the partial result already in dst.
        rf_rd_addr = dst_q;
        sh_ctrl    = pass2_amt;
        sh_sel     = (op_q == OP_SHR);
        wb_sel     = 1'b1;
        rf_wr      = 1'b1;
        rf_wr_addr = dst_q;
      end
      ST_FIN: begin
        done       = 1'b1;
        err        = (op_q == OP_ILL);
        rf_rd_addr = dst_q;
      end
      default: begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer with register file and shifters

module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_src;
  logic [2:0] cmd_dst;
  logic [3:0] cmd_amt;
  logic [7:0] cmd_data;
  logic [2:0] rf_rd_addr;
  logic [2:0] rf_wr_addr;
  logic       rf_wr;
  logic [2:0] sh_ctrl;
  logic       sh_sel;
  logic       wb_sel;
  logic [7:0] rf_d_in;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] ops_cnt;

  always #5 clk = ~clk;

  shift_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_src    (cmd_src),
    .cmd_dst    (cmd_dst),
    .cmd_amt    (cmd_amt),
    .cmd_data   (cmd_data),
    .rf_rd_addr (rf_rd_addr),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr      (rf_wr),
    .sh_ctrl    (sh_ctrl),
    .sh_sel     (sh_sel),
    .wb_sel     (wb_sel),
    .rf_d_in    (rf_d_in),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ops_cnt    (ops_cnt)
  );

  // Datapath around the sequencer: register file, two shifters, muxes.
  logic [7:0] rf [8];
  logic [7:0] rd_data;
  logic [7:0] sh_out;
  logic [7:0] wb_data;

  assign rd_data = rf[rf_rd_addr];
  assign sh_out  = sh_sel ? (rd_data >> sh_ctrl) : (rd_data << sh_ctrl);
  assign wb_data = wb_sel ? sh_out : rf_d_in;

  always @(posedge clk) begin
    if (rf_wr) rf[rf_wr_addr] <= wb_data;
  end

  // Observed output bundle, compared against whole expected vectors.
  logic [23:0] obs;
  assign obs = {cmd_ready, busy, done, err, rf_wr, rf_wr_addr, rf_rd_addr,
                sh_ctrl, sh_sel, wb_sel, rf_d_in};

  localparam logic [23:0] IDLE_VEC = 24'h800000;

  // Reference model: architectural register contents and command count.
  logic [7:0] m [8];
  logic [7:0] known = 8'd0;
  int         exp_ops = 0;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_garbage();
    cmd_op   = 2'($urandom);
    cmd_src  = 3'($urandom);
    cmd_dst  = 3'($urandom);
    cmd_amt  = 4'($urandom);
    cmd_data = 8'($urandom);
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      if (known[i]) chk($sformatf("%s_r%0d", tag, i), rf[i], m[i]);
    end
  endtask

  function automatic logic [23:0] busy_vec(input logic [1:0] op, input logic [2:0] src,
                                           input logic [2:0] dst, input logic [3:0] amt,
                                           input logic [7:0] data, input int k, input int lat);
    int amt_i;
    int pass_amt;
    amt_i = int'(amt);
    if (k == lat)
      return {1'b0, 1'b1, 1'b1, (op == 2'd3), 1'b0, 3'd0, dst, 3'd0, 1'b0, 1'b0, 8'd0};
    if (op == 2'd0)
      return {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, dst, 3'd0, 3'd0, 1'b0, 1'b0, data};
    if (k == 1) pass_amt = (amt_i > 7) ? 7 : amt_i;
    else        pass_amt = (amt_i - 7 > 7) ? 7 : amt_i - 7;
    return {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, dst, (k == 1) ? src : dst,
            3'(pass_amt), (op == 2'd2), 1'b1, 8'd0};
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                         input logic [3:0] amt, input logic [7:0] data, input bit hold);
    int lat;
    logic [15:0] wide;
    chk("ready_pre", obs, IDLE_VEC);
    cmd_op    = op;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_amt   = amt;
    cmd_data  = data;
    cmd_valid = 1'b1;
    tick();
    if (hold) drive_garbage();
    else cmd_valid = 1'b0;
    lat = (op == 2'd3) ? 1 : (op == 2'd0) ? 2 : (amt > 4'd7) ? 3 : 2;
    for (int k = 1; k <= lat; k++) begin
      chk($sformatf("op%0d_amt%0d_cyc%0d", op, amt, k), obs, busy_vec(op, src, dst, amt, data, k, lat));
      tick();
      if (hold) drive_garbage();
    end
    cmd_valid = 1'b0;
    case (op)
      2'd0: begin
        m[dst] = data;
        known[dst] = 1'b1;
      end
      2'd1: begin
        wide = {8'd0, m[src]} << amt;
        known[dst] = known[src];
        m[dst] = wide[7:0];
      end
      2'd2: begin
        known[dst] = known[src];
        m[dst] = m[src] >> amt;
      end
      default: ;
    endcase
    exp_ops = (exp_ops + 1) % 256;
    chk("idle_post", obs, IDLE_VEC);
    chk("ops_cnt", ops_cnt, exp_ops);
    chk_regs("rf");
  endtask

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b1;
    drive_garbage();
    tick();
    drive_garbage();
    tick();
    chk("reset_vec", obs, IDLE_VEC);
    chk("reset_ops", ops_cnt, 0);
    reset     = 1'b1;
    cmd_valid = 1'b0;
    tick();
    chk("post_reset_vec", obs, IDLE_VEC);

    run_cmd(2'd0, 3'd0, 3'd3, 4'd0, 8'hA5, 1'b0);
    chk("load_r3", rf[3], 8'hA5);
    run_cmd(2'd1, 3'd3, 3'd4, 4'd3, 8'h00, 1'b0);
    chk("shl_r4", rf[4], 8'h28);
    run_cmd(2'd2, 3'd3, 3'd5, 4'd2, 8'h00, 1'b0);
    chk("shr_r5", rf[5], 8'h29);
    run_cmd(2'd0, 3'd0, 3'd1, 4'd0, 8'hFF, 1'b0);
    run_cmd(2'd2, 3'd1, 3'd1, 4'd9, 8'h00, 1'b0);
    chk("shr9_r1", rf[1], 8'h00);
    run_cmd(2'd3, 3'd2, 3'd3, 4'd5, 8'h11, 1'b0);
    chk("ill_r3", rf[3], 8'hA5);

    run_cmd(2'd0, 3'd0, 3'd0, 4'd0, 8'($urandom), 1'b0);
    run_cmd(2'd0, 3'd0, 3'd2, 4'd0, 8'($urandom), 1'b0);
    run_cmd(2'd0, 3'd0, 3'd6, 4'd0, 8'($urandom), 1'b0);
    run_cmd(2'd0, 3'd0, 3'd7, 4'd0, 8'($urandom), 1'b1);
    run_cmd(2'd2, 3'd5, 3'd5, 4'd0, 8'h00, 1'b1);
    run_cmd(2'd1, 3'd4, 3'd2, 4'd15, 8'h00, 1'b1);
    run_cmd(2'd1, 3'd3, 3'd6, 4'd8, 8'h00, 1'b1);

    // Reset in the first pass of a two-pass shift aborts it.
    chk("abort_ready", obs, IDLE_VEC);
    cmd_op    = 2'd1;
    cmd_src   = 3'd2;
    cmd_dst   = 3'd6;
    cmd_amt   = 4'd12;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("abort_sh1", obs, busy_vec(2'd1, 3'd2, 3'd6, 4'd12, 8'd0, 1, 3));
    reset     = 1'b0;
    cmd_valid = 1'b1;
    drive_garbage();
    known[6]  = 1'b0;
    tick();
    chk("abort_rst_vec", obs, IDLE_VEC);
    chk("abort_rst_ops", ops_cnt, 0);
    drive_garbage();
    tick();
    chk("abort_rst_vec2", obs, IDLE_VEC);
    reset     = 1'b1;
    cmd_valid = 1'b0;
    exp_ops   = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("abort_idle%0d", i), obs, IDLE_VEC);
    end
    chk_regs("abort");

    for (int n = 0; n < 256; n++) begin
      run_cmd(2'($urandom), 3'($urandom), 3'($urandom), 4'($urandom), 8'($urandom),
              1'($urandom));
    end
    chk("wrap_ops", ops_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
